// File: rtl/dti_boost_loader.sv
// -----------------------------------------------------------------------------
// dti_boost_loader
//
// UART boot-loader front end. Serial characters on rx are received with
// configurable framing (5..8 data bits, none/even/odd parity, 1 or 2 stop
// bits), packed BYTES_PER_WORD at a time into an instruction word, and
// offered on a valid/ready interface with an auto-incrementing word address.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   rx           serial data in (asynchronous, idle high)
//   rts_n        flow control, 1 = sender must pause (mirrors word_valid)
//   word_data    assembled word, first received byte in bits [7:0]
//   word_addr    address of the word currently presented
//   word_valid   word_data/word_addr valid
//   word_ready   consumer accepts the presented word
//   err_frame    sticky: a stop bit was sampled low
//   err_parity   sticky: parity mismatch
//   err_overrun  sticky: word completed while the previous one was still held
//   err_clear    clears all sticky error flags
//
// Optional feature macro: BOOST_RX_MAJORITY_EN
//   Defined   : every bit decision is a 2-of-3 vote of the samples taken at
//               sample indices 6, 7 and 8, decided at index 8.
//   Undefined : every bit decision is the single sample at index 7.
// -----------------------------------------------------------------------------

`ifndef CFG_BAUDRATE
`define CFG_BAUDRATE 115200
`endif
`ifndef CFG_FREQ_FPGA
`define CFG_FREQ_FPGA 50000000
`endif

module dti_boost_loader #(
    parameter int BAUDRATE          = `CFG_BAUDRATE,
    parameter int FREQ_FPGA         = `CFG_FREQ_FPGA,
    parameter int DATA_BITS         = 8,
    parameter int PARITY_MODE       = 0,
    parameter int STOP_BITS         = 1,
    parameter int BYTES_PER_WORD    = 4,
    parameter int WORD_WIDTH        = 8 * BYTES_PER_WORD,
    parameter int ADDR_WIDTH        = 10,
    parameter int IDLE_TIMEOUT_BITS = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx,
    output logic                  rts_n,
    output logic [WORD_WIDTH-1:0] word_data,
    output logic [ADDR_WIDTH-1:0] word_addr,
    output logic                  word_valid,
    input  logic                  word_ready,
    output logic                  err_frame,
    output logic                  err_parity,
    output logic                  err_overrun,
    input  logic                  err_clear
);

    localparam int DIV      = FREQ_FPGA / (BAUDRATE * 16);
    localparam int DW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BCW      = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam int TO_TICKS = IDLE_TIMEOUT_BITS * 16;
    localparam int TOW      = (TO_TICKS > 1) ? $clog2(TO_TICKS) : 1;
    localparam logic PAR_ODD = (PARITY_MODE == 2);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              rx_meta;
    logic              rx_sync;
    logic [DW-1:0]     div_cnt;
    logic              tick;
    logic [3:0]        samp_idx;
    logic              decide;
    logic              at_end;
    logic              start_det;
    logic              bit_val;
    logic [2:0]        bit_cnt;
    logic              stop_cnt;
    logic [7:0]        char_data;
    logic              par_bad;
    logic              frm_bad;
    logic              frm_now;
    logic              commit;
    logic              commit_good;
    logic              last_lane;
    logic              word_done;
    logic [BCW-1:0]    byte_cnt;
    logic [WORD_WIDTH-1:0] asm_word;
    logic [WORD_WIDTH-1:0] full_word;
    logic [TOW-1:0]    to_cnt;
    logic              timeout_hit;
    logic              handshake;
    logic              valid_nxt;
    logic              load_word;
    logic              overrun_evt;

    // Two-flop synchroniser; resets to the idle-high line level so a reset
    // never looks like a start bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    // Free-running oversampling divider: one tick per 1/16 bit-time.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt <= '0;
        end else if (div_cnt == DW'(DIV - 1)) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DW'(1);
        end
    end

    assign tick = (div_cnt == DW'(DIV - 1));

`ifdef BOOST_RX_MAJORITY_EN
    localparam logic [3:0] DEC_IDX = 4'd8;
    logic samp6;
    logic samp7;

    // Early votes for the 2-of-3 decision taken at index 8.
    always_ff @(posedge clk) begin
        if (reset) begin
            samp6 <= 1'b1;
            samp7 <= 1'b1;
        end else if (tick) begin
            if (samp_idx == 4'd6) samp6 <= rx_sync;
            if (samp_idx == 4'd7) samp7 <= rx_sync;
        end
    end

    assign bit_val = (samp6 & samp7) | (samp6 & rx_sync) | (samp7 & rx_sync);
`else
    localparam logic [3:0] DEC_IDX = 4'd7;
    assign bit_val = rx_sync;
`endif

    assign decide    = tick && (samp_idx == DEC_IDX);
    assign at_end    = tick && (samp_idx == 4'd15);
    assign start_det = (state == IDLE) && tick && !rx_sync;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state. STOP leaves right after its decision so back-to-back
    // characters get half a bit of margin to find the next start edge.
    always_comb begin
        state_nxt = state;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                if (start_det) state_nxt = START;
            end
            START: begin
                if (decide && bit_val) begin
                    state_nxt = IDLE;
                end else if (at_end) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (at_end && (bit_cnt == 3'(DATA_BITS - 1))) begin
                    state_nxt = (PARITY_MODE != 0) ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (at_end) state_nxt = STOP;
            end
            STOP: begin
                if (decide && (stop_cnt == 1'(STOP_BITS - 1))) begin
                    state_nxt = IDLE;
                    commit    = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Per-character datapath: sample index, bit counters, data shift-in and
    // the per-character error accumulators (cleared at each start edge).
    always_ff @(posedge clk) begin
        if (reset) begin
            samp_idx  <= 4'd0;
            bit_cnt   <= 3'd0;
            stop_cnt  <= 1'b0;
            char_data <= 8'd0;
            par_bad   <= 1'b0;
            frm_bad   <= 1'b0;
        end else begin
            if (state == IDLE) begin
                samp_idx <= 4'd0;
                if (start_det) begin
                    bit_cnt   <= 3'd0;
                    stop_cnt  <= 1'b0;
                    char_data <= 8'd0;
                    par_bad   <= 1'b0;
                    frm_bad   <= 1'b0;
                end
            end else if (tick) begin
                samp_idx <= samp_idx + 4'd1;
            end

            if (decide) begin
                case (state)
                    DATA:   char_data[bit_cnt] <= bit_val;
                    PARITY: par_bad <= (bit_val != ((^char_data) ^ PAR_ODD));
                    STOP: begin
                        frm_bad  <= frm_bad | ~bit_val;
                        stop_cnt <= 1'b1;
                    end
                    default: ;
                endcase
            end

            if (at_end && (state == DATA)) begin
                bit_cnt <= (bit_cnt == 3'(DATA_BITS - 1)) ? 3'd0 : bit_cnt + 3'd1;
            end
        end
    end

    assign frm_now     = frm_bad | ~bit_val;
    assign commit_good = commit && !frm_now && !par_bad;
    assign last_lane   = (byte_cnt == BCW'(BYTES_PER_WORD - 1));
    assign word_done   = commit_good && last_lane;

    // The word as it looks with the committing character in its lane.
    always_comb begin
        full_word = asm_word;
        full_word[byte_cnt*8 +: 8] = char_data;
    end

    // Partial-word discard after a long idle line; only counts while a
    // partial word exists.
    assign timeout_hit = (TO_TICKS != 0) && (state == IDLE) && (byte_cnt != '0)
                         && tick && (to_cnt == TOW'(TO_TICKS - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt <= '0;
        end else if ((state != IDLE) || (byte_cnt == '0) || timeout_hit) begin
            to_cnt <= '0;
        end else if (tick) begin
            to_cnt <= to_cnt + TOW'(1);
        end
    end

    // Word assembly: good characters fill lanes in order; a bad character
    // or an idle timeout throws the partial word away.
    always_ff @(posedge clk) begin
        if (reset) begin
            byte_cnt <= '0;
            asm_word <= '0;
        end else if (commit) begin
            if (commit_good) begin
                asm_word <= full_word;
                byte_cnt <= last_lane ? '0 : byte_cnt + BCW'(1);
            end else begin
                byte_cnt <= '0;
            end
        end else if (timeout_hit) begin
            byte_cnt <= '0;
        end
    end

    // Output holding register. A completion in the same cycle as a handshake
    // replaces the accepted word without a valid gap.
    assign handshake = word_valid & word_ready;

    always_comb begin
        valid_nxt   = word_valid;
        load_word   = 1'b0;
        overrun_evt = 1'b0;
        if (handshake) valid_nxt = 1'b0;
        if (word_done) begin
            if (!word_valid || handshake) begin
                load_word = 1'b1;
                valid_nxt = 1'b1;
            end else begin
                overrun_evt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            word_data  <= '0;
            word_addr  <= '0;
            word_valid <= 1'b0;
            rts_n      <= 1'b0;
        end else begin
            word_valid <= valid_nxt;
            rts_n      <= valid_nxt;
            if (load_word) word_data <= full_word;
            if (handshake) word_addr <= word_addr + ADDR_WIDTH'(1);
        end
    end

    // Sticky error flags; a new error event beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_frame   <= 1'b0;
            err_parity  <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            err_frame   <= (err_frame   & ~err_clear) | (commit && frm_now);
            err_parity  <= (err_parity  & ~err_clear) | (commit && par_bad);
            err_overrun <= (err_overrun & ~err_clear) | overrun_evt;
        end
    end

endmodule

// File: tb/tb_dti_boost_loader.sv
`timescale 1ns/1ps

module tb_dti_boost_loader;

    localparam int BIT_CLKS = 64;

    logic        clk;
    logic        reset;
    logic        rx;
    logic        rx_p;
    logic        word_ready;
    logic        err_clear;

    logic        rts_n, word_valid, err_frame, err_parity, err_overrun;
    logic [31:0] word_data;
    logic [9:0]  word_addr;
    logic        rts_n_p, word_valid_p, err_frame_p, err_parity_p, err_overrun_p;
    logic [31:0] word_data_p;
    logic [9:0]  word_addr_p;

    dti_boost_loader #(.BAUDRATE(100), .FREQ_FPGA(6400)) dut (
        .clk(clk), .reset(reset), .rx(rx), .rts_n(rts_n),
        .word_data(word_data), .word_addr(word_addr), .word_valid(word_valid),
        .word_ready(word_ready), .err_frame(err_frame), .err_parity(err_parity),
        .err_overrun(err_overrun), .err_clear(err_clear)
    );

    dti_boost_loader #(.BAUDRATE(100), .FREQ_FPGA(6400), .PARITY_MODE(1)) dut_p (
        .clk(clk), .reset(reset), .rx(rx_p), .rts_n(rts_n_p),
        .word_data(word_data_p), .word_addr(word_addr_p), .word_valid(word_valid_p),
        .word_ready(word_ready), .err_frame(err_frame_p), .err_parity(err_parity_p),
        .err_overrun(err_overrun_p), .err_clear(err_clear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        which;
        logic [31:0] data;
        logic [9:0]  addr;
    } xfer_t;

    xfer_t obs_q[$];
    xfer_t exp_q[$];

    int checks = 0;
    int errors = 0;

    // Reference model state, one slot per DUT (0 = no parity, 1 = even parity)
    logic [7:0]  part[2][4];
    int          part_n[2];
    logic [9:0]  next_addr[2];
    logic        held[2];
    logic [31:0] held_word[2];
    logic        e_frame[2], e_par[2], e_ovr[2];

    // Record every accepted word, sampled mid-cycle while inputs are stable
    always @(negedge clk) begin
        xfer_t x;
        if (!reset && word_valid && word_ready) begin
            x.which = 1'b0; x.data = word_data; x.addr = word_addr;
            obs_q.push_back(x);
        end
        if (!reset && word_valid_p && word_ready) begin
            x.which = 1'b1; x.data = word_data_p; x.addr = word_addr_p;
            obs_q.push_back(x);
        end
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic wait_clks(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_line(input int which, input logic v);
        if (which == 0) rx = v;
        else rx_p = v;
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            part_n[d] = 0; next_addr[d] = '0; held[d] = 1'b0; held_word[d] = '0;
            e_frame[d] = 1'b0; e_par[d] = 1'b0; e_ovr[d] = 1'b0;
        end
    endtask

    task automatic model_char(input int which, input logic [7:0] data,
                              input logic ok_frame, input logic ok_par);
        logic [31:0] w;
        xfer_t x;
        if (!ok_frame) e_frame[which] = 1'b1;
        if (!ok_par) e_par[which] = 1'b1;
        if (!ok_frame || !ok_par) begin
            part_n[which] = 0;
        end else begin
            part[which][part_n[which]] = data;
            part_n[which]++;
            if (part_n[which] == 4) begin
                part_n[which] = 0;
                w = {part[which][3], part[which][2], part[which][1], part[which][0]};
                if (word_ready) begin
                    x.which = (which != 0); x.data = w; x.addr = next_addr[which];
                    exp_q.push_back(x);
                    next_addr[which]++;
                end else if (!held[which]) begin
                    held[which] = 1'b1;
                    held_word[which] = w;
                end else begin
                    e_ovr[which] = 1'b1;
                end
            end
        end
    endtask

    task automatic model_release(input int which);
        xfer_t x;
        if (held[which]) begin
            x.which = (which != 0); x.data = held_word[which]; x.addr = next_addr[which];
            exp_q.push_back(x);
            next_addr[which]++;
            held[which] = 1'b0;
        end
    endtask

    // One character: start, 8 data bits LSB first, optional even parity,
    // one stop bit; a bad stop bit is held low just past its mid-point.
    task automatic send_char(input int which, input logic [7:0] data,
                             input logic bad_stop, input logic bad_par);
        drive_line(which, 1'b0);
        wait_clks(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            drive_line(which, data[i]);
            wait_clks(BIT_CLKS);
        end
        if (which == 1) begin
            drive_line(which, (^data) ^ bad_par);
            wait_clks(BIT_CLKS);
        end
        if (bad_stop) begin
            drive_line(which, 1'b0);
            wait_clks(40);
            drive_line(which, 1'b1);
            wait_clks(BIT_CLKS - 40);
        end else begin
            drive_line(which, 1'b1);
            wait_clks(BIT_CLKS);
        end
        wait_clks(32);
        model_char(which, data, !bad_stop, !(bad_par && which == 1));
    endtask

    task automatic pulse_err_clear();
        err_clear = 1'b1;
        wait_clks(1);
        err_clear = 1'b0;
        for (int d = 0; d < 2; d++) begin
            e_frame[d] = 1'b0; e_par[d] = 1'b0; e_ovr[d] = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        wait_clks(4);
        reset = 1'b0;
        model_reset();
        wait_clks(2);
        checks += 14;
        if (word_data !== 32'h0)   begin errors++; $display("[TB] FAIL rst_data: got %h want 0", word_data); end
        if (word_addr !== 10'h0)   begin errors++; $display("[TB] FAIL rst_addr: got %0d want 0", word_addr); end
        if (word_valid !== 1'b0)   begin errors++; $display("[TB] FAIL rst_valid: got %b want 0", word_valid); end
        if (rts_n !== 1'b0)        begin errors++; $display("[TB] FAIL rst_rts: got %b want 0", rts_n); end
        if (err_frame !== 1'b0)    begin errors++; $display("[TB] FAIL rst_efrm: got %b want 0", err_frame); end
        if (err_parity !== 1'b0)   begin errors++; $display("[TB] FAIL rst_epar: got %b want 0", err_parity); end
        if (err_overrun !== 1'b0)  begin errors++; $display("[TB] FAIL rst_eovr: got %b want 0", err_overrun); end
        if (word_data_p !== 32'h0) begin errors++; $display("[TB] FAIL rst_data_p: got %h want 0", word_data_p); end
        if (word_addr_p !== 10'h0) begin errors++; $display("[TB] FAIL rst_addr_p: got %0d want 0", word_addr_p); end
        if (word_valid_p !== 1'b0) begin errors++; $display("[TB] FAIL rst_valid_p: got %b want 0", word_valid_p); end
        if (rts_n_p !== 1'b0)      begin errors++; $display("[TB] FAIL rst_rts_p: got %b want 0", rts_n_p); end
        if (err_frame_p !== 1'b0)  begin errors++; $display("[TB] FAIL rst_efrm_p: got %b want 0", err_frame_p); end
        if (err_parity_p !== 1'b0) begin errors++; $display("[TB] FAIL rst_epar_p: got %b want 0", err_parity_p); end
        if (err_overrun_p !== 1'b0) begin errors++; $display("[TB] FAIL rst_eovr_p: got %b want 0", err_overrun_p); end
    endtask

    task automatic test_basic_word();
        obs_q.delete(); exp_q.delete();
        send_char(0, 8'h13, 0, 0);
        send_char(0, 8'h00, 0, 0);
        send_char(0, 8'h50, 0, 0);
        send_char(0, 8'h00, 0, 0);
        checks++;
        if (obs_q.size() !== 1) begin
            errors++; $display("[TB] FAIL basic_pulses: got %0d words want 1", obs_q.size());
        end else begin
            checks += 2;
            if (obs_q[0].data !== 32'h00500013) begin errors++; $display("[TB] FAIL basic_data: got %h want 00500013", obs_q[0].data); end
            if (obs_q[0].addr !== 10'd0) begin errors++; $display("[TB] FAIL basic_addr: got %0d want 0", obs_q[0].addr); end
        end
        for (int i = 0; i < 4; i++) send_char(0, 8'($urandom_range(0, 255)), 0, 0);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++; $display("[TB] FAIL basic_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("[TB] FAIL basic_xfer%0d: got %h@%0d want %h@%0d", i, obs_q[i].data, obs_q[i].addr, exp_q[i].data, exp_q[i].addr);
                end
            end
        end
    endtask

    task automatic test_overrun();
        obs_q.delete(); exp_q.delete();
        word_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_char(0, 8'($urandom_range(0, 255)), 0, 0);
        checks += 4;
        if (word_valid !== 1'b1) begin errors++; $display("[TB] FAIL ovr_valid: got %b want 1", word_valid); end
        if (rts_n !== 1'b1) begin errors++; $display("[TB] FAIL ovr_rts: got %b want 1", rts_n); end
        if (word_data !== held_word[0]) begin errors++; $display("[TB] FAIL ovr_held: got %h want %h", word_data, held_word[0]); end
        if (word_addr !== next_addr[0]) begin errors++; $display("[TB] FAIL ovr_addr: got %0d want %0d", word_addr, next_addr[0]); end
        for (int i = 0; i < 4; i++) send_char(0, 8'($urandom_range(0, 255)), 0, 0);
        checks += 2;
        if (err_overrun !== e_ovr[0]) begin errors++; $display("[TB] FAIL ovr_flag: got %b want %b", err_overrun, e_ovr[0]); end
        if (word_data !== held_word[0]) begin errors++; $display("[TB] FAIL ovr_stable: got %h want %h", word_data, held_word[0]); end
        word_ready = 1'b1;
        model_release(0);
        wait_clks(4);
        checks += 3;
        if (word_valid !== 1'b0) begin errors++; $display("[TB] FAIL ovr_drain: got %b want 0", word_valid); end
        if (rts_n !== 1'b0) begin errors++; $display("[TB] FAIL ovr_rts_drain: got %b want 0", rts_n); end
        if (obs_q.size() !== exp_q.size()) begin
            errors++; $display("[TB] FAIL ovr_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("[TB] FAIL ovr_xfer%0d: got %h@%0d want %h@%0d", i, obs_q[i].data, obs_q[i].addr, exp_q[i].data, exp_q[i].addr);
                end
            end
        end
    endtask

    task automatic test_parity();
        obs_q.delete(); exp_q.delete();
        send_char(1, 8'h01, 0, 1);
        checks += 2;
        if (err_parity_p !== e_par[1]) begin errors++; $display("[TB] FAIL par_flag: got %b want %b", err_parity_p, e_par[1]); end
        if (err_frame_p !== e_frame[1]) begin errors++; $display("[TB] FAIL par_frame: got %b want %b", err_frame_p, e_frame[1]); end
        for (int i = 0; i < 4; i++) send_char(1, 8'($urandom_range(0, 255)), 0, 0);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++; $display("[TB] FAIL par_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("[TB] FAIL par_xfer%0d: got %h@%0d want %h@%0d", i, obs_q[i].data, obs_q[i].addr, exp_q[i].data, exp_q[i].addr);
                end
            end
        end
        pulse_err_clear();
        checks += 2;
        if (err_parity_p !== 1'b0) begin errors++; $display("[TB] FAIL par_clear: got %b want 0", err_parity_p); end
        if (err_overrun !== 1'b0) begin errors++; $display("[TB] FAIL ovr_clear: got %b want 0", err_overrun); end
    endtask

    task automatic test_frame();
        obs_q.delete(); exp_q.delete();
        send_char(0, 8'h5A, 0, 0);
        send_char(0, 8'hC3, 1, 0);
        checks++;
        if (err_frame !== e_frame[0]) begin errors++; $display("[TB] FAIL frm_flag: got %b want %b", err_frame, e_frame[0]); end
        send_char(0, 8'hAA, 0, 0);
        send_char(0, 8'hBB, 0, 0);
        send_char(0, 8'hCC, 0, 0);
        send_char(0, 8'hDD, 0, 0);
        checks++;
        if (obs_q.size() !== 1) begin
            errors++; $display("[TB] FAIL frm_count: got %0d want 1", obs_q.size());
        end else begin
            checks += 2;
            if (obs_q[0].data !== 32'hDDCCBBAA) begin errors++; $display("[TB] FAIL frm_data: got %h want DDCCBBAA", obs_q[0].data); end
            if (obs_q[0] !== exp_q[0]) begin errors++; $display("[TB] FAIL frm_xfer: got %h@%0d want %h@%0d", obs_q[0].data, obs_q[0].addr, exp_q[0].data, exp_q[0].addr); end
        end
    endtask

    task automatic test_glitch_and_timeout();
        obs_q.delete(); exp_q.delete();
        pulse_err_clear();
        rx = 1'b0;
        wait_clks(2);
        rx = 1'b1;
        wait_clks(2 * BIT_CLKS);
        checks += 3;
        if (err_frame !== 1'b0) begin errors++; $display("[TB] FAIL glitch_frame: got %b want 0", err_frame); end
        if (err_parity !== 1'b0) begin errors++; $display("[TB] FAIL glitch_parity: got %b want 0", err_parity); end
        if (word_valid !== 1'b0) begin errors++; $display("[TB] FAIL glitch_valid: got %b want 0", word_valid); end
        for (int i = 0; i < 4; i++) send_char(0, 8'($urandom_range(0, 255)), 0, 0);
        send_char(0, 8'($urandom_range(0, 255)), 0, 0);
        send_char(0, 8'($urandom_range(0, 255)), 0, 0);
        wait_clks(36 * BIT_CLKS);
        part_n[0] = 0;
        for (int i = 0; i < 4; i++) send_char(0, 8'($urandom_range(0, 255)), 0, 0);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++; $display("[TB] FAIL tmo_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("[TB] FAIL tmo_xfer%0d: got %h@%0d want %h@%0d", i, obs_q[i].data, obs_q[i].addr, exp_q[i].data, exp_q[i].addr);
                end
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] b;
        obs_q.delete(); exp_q.delete();
        send_char(0, 8'h77, 1, 0);
        send_char(0, 8'($urandom_range(0, 255)), 0, 0);
        send_char(0, 8'($urandom_range(0, 255)), 0, 0);
        b = 8'($urandom_range(0, 255));
        rx = 1'b0;
        wait_clks(BIT_CLKS);
        for (int i = 0; i < 3; i++) begin
            rx = b[i];
            wait_clks(BIT_CLKS);
        end
        wait_clks(20);
        reset = 1'b1;
        rx = 1'b1;
        wait_clks(3);
        checks += 6;
        if (word_data !== 32'h0)  begin errors++; $display("[TB] FAIL mrst_data: got %h want 0", word_data); end
        if (word_addr !== 10'h0)  begin errors++; $display("[TB] FAIL mrst_addr: got %0d want 0", word_addr); end
        if (word_valid !== 1'b0)  begin errors++; $display("[TB] FAIL mrst_valid: got %b want 0", word_valid); end
        if (rts_n !== 1'b0)       begin errors++; $display("[TB] FAIL mrst_rts: got %b want 0", rts_n); end
        if (err_frame !== 1'b0)   begin errors++; $display("[TB] FAIL mrst_efrm: got %b want 0", err_frame); end
        if (err_overrun !== 1'b0) begin errors++; $display("[TB] FAIL mrst_eovr: got %b want 0", err_overrun); end
        reset = 1'b0;
        model_reset();
        wait_clks(2 * BIT_CLKS);
        for (int i = 0; i < 4; i++) send_char(0, 8'($urandom_range(0, 255)), 0, 0);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++; $display("[TB] FAIL mrst_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("[TB] FAIL mrst_xfer%0d: got %h@%0d want %h@%0d", i, obs_q[i].data, obs_q[i].addr, exp_q[i].data, exp_q[i].addr);
                end
            end
        end
    endtask

    task automatic test_random_stream();
        logic bad;
        obs_q.delete(); exp_q.delete();
        for (int k = 0; k < 16; k++) begin
            bad = ($urandom_range(0, 5) == 0);
            send_char(0, 8'($urandom_range(0, 255)), bad, 0);
            if ($urandom_range(0, 7) == 0) begin
                wait_clks(36 * BIT_CLKS);
                part_n[0] = 0;
            end else begin
                wait_clks($urandom_range(0, 30));
            end
        end
        checks += 2;
        if (err_frame !== e_frame[0]) begin errors++; $display("[TB] FAIL rnd_frame: got %b want %b", err_frame, e_frame[0]); end
        if (obs_q.size() !== exp_q.size()) begin
            errors++; $display("[TB] FAIL rnd_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("[TB] FAIL rnd_xfer%0d: got %h@%0d want %h@%0d", i, obs_q[i].data, obs_q[i].addr, exp_q[i].data, exp_q[i].addr);
                end
            end
        end
    endtask

    initial begin
        reset      = 1'b1;
        rx         = 1'b1;
        rx_p       = 1'b1;
        word_ready = 1'b1;
        err_clear  = 1'b0;
        model_reset();
        wait_clks(2);
        test_reset();
        test_basic_word();
        test_overrun();
        test_parity();
        test_frame();
        test_glitch_and_timeout();
        test_reset_mid_frame();
        test_random_stream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
